rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one grant may be held (legal range 2..255).
REQ-002 Parameter: FIXED_PRI, default 0, 0 = round-robin, 1 = fixed priority with req[3] highest and req[0] lowest.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  request lines, one per requester, level-sensitive.
REQ-006 Port: done  input  1  current owner finished; sampled only in GRANT.
REQ-007 Port: gnt  output  4  registered one-hot grant; all zeros when no owner.
REQ-008 Port: gnt_id  output  2  registered binary index of the owner; holds its last value when gnt_valid=0.
REQ-009 Port: gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-010 Port: timeout  output  1  registered one-cycle pulse on a forced release.

Function
REQ-011 FSM states: IDLE and GRANT; the reset state is IDLE.
REQ-012 IDLE with req=0000: remain in IDLE; gnt=0000, gnt_valid=0.
REQ-013 IDLE with any req bit set: select a winner, enter GRANT next cycle, set gnt=onehot(winner), gnt_id=winner, gnt_valid=1 (one-cycle latency from req to gnt).
REQ-014 Round-robin selection (FIXED_PRI=0): search indices ascending from (last_id+1) mod 4 with wrap-around; the first asserted req wins.
REQ-015 Fixed-priority selection (FIXED_PRI=1): the highest asserted index wins; last_id is ignored.
REQ-016 last_id is an internal 2-bit register that loads the winner when the grant is issued; its reset value is 3, so the first round-robin search order is 0,1,2,3.
REQ-017 GRANT, hold counter: starts at 1 in the first grant cycle and increments each GRANT cycle; saturates at MAX_HOLD.
REQ-018 GRANT, release: a release condition occurs in any cycle where done=1, or req[gnt_id]=0, or hold counter=MAX_HOLD.
REQ-019 On release: next cycle state=IDLE, gnt=0000, gnt_valid=0; this gives at least one dead cycle between grants.
REQ-020 Timeout: the pulse asserts in that release's next cycle only when the release was due to the counter limit while done=0 and req[gnt_id]=1.
REQ-021 Simultaneous done (or req drop) and counter limit: treated as a normal release; timeout stays 0.
REQ-022 In GRANT, changes on other req bits do not affect gnt; there is no preemption.
REQ-023 A released requester that is still requesting rearbitrates normally from IDLE; in round-robin it is last in order.
REQ-024 gnt is one-hot or zero in every cycle; gnt_valid=|gnt.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, hold counter=0, last_id=3.
REQ-026 Reset dominates every other input, including during GRANT; there is no grant in the first cycle after rst is released.

Verification
REQ-027 Reset then arbitrate: rst=1 for 2 cycles, then req=0101 -> gnt=0000 during reset; gnt=0001, gnt_id=0, gnt_valid=1 in the cycle after the first non-reset edge.
REQ-028 Round-robin fairness: FIXED_PRI=0, req=1111 constant, done=1 in each grant's first cycle -> gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 Fixed priority: FIXED_PRI=1, req=0110 -> gnt=0100, gnt_id=2; after done, gnt=0100 again while req is unchanged.
REQ-030 Timeout: MAX_HOLD=8, req=0001 held, done=0 -> gnt=0001 for exactly 8 cycles, then gnt=0000 with timeout=1 for one cycle, then regrant 0001.
REQ-031 Owner drop and no preemption: owner 1 granted, req changes from 0010 to 1001 mid-grant -> gnt=0000 the next cycle, timeout=0, then gnt=1000 in round-robin mode.
REQ-032 Reset mid-grant: rst=1 in the 3rd grant cycle -> gnt=0000 the next cycle; last_id=3, so req=1111 then grants 0001.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way arbiter (round-robin or fixed priority) with bounded hold; grant appears one cycle after request.
// No backpressure: owner keeps grant until done, request drop or MAX_HOLD, then one forced idle cycle.
module rr_arbiter4 #(
    parameter int MAX_HOLD  = 8,
    parameter int FIXED_PRI = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] last_id;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       at_limit;
    logic       early_rel;
    logic       release_now;

    always_comb begin
        winner = 2'd0;
        idx    = 2'd0;
        found  = 1'b0;
        if (FIXED_PRI != 0) begin
            for (int i = 3; i >= 0; i--) begin
                if (!found && req[i]) begin
                    winner = 2'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            // Offset 4 wraps back to last_id itself, so the previous owner is searched last.
            for (int i = 1; i <= 4; i++) begin
                idx = last_id + 2'(i);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    assign at_limit    = (hold_cnt == MAX_HOLD_C);
    assign early_rel   = done || !req[gnt_id];
    assign release_now = early_rel || at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= 8'd0;
            last_id   <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << winner;
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd1;
                        last_id   <= winner;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= 8'd0;
                        // Only a pure hold-limit expiry counts as a forced release.
                        timeout   <= at_limit && !early_rel;
                    end else begin
                        timeout  <= 1'b0;
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: round-robin (MAX_HOLD=8) and fixed-priority (MAX_HOLD=3) instances share stimulus,
// each compared every cycle against an owner/hold-count reference model plus directed expectations.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt_rr, gnt_fp;
    logic [1:0] id_rr, id_fp;
    logic       vld_rr, vld_fp;
    logic       to_rr, to_fp;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    localparam int MH [2] = '{8, 3};
    localparam int FP [2] = '{0, 1};

    int m_owner [2];
    int m_held  [2];
    int m_last  [2];
    int m_id    [2];
    bit m_to    [2];

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8), .FIXED_PRI(0)) u_rr (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_rr), .gnt_id(id_rr), .gnt_valid(vld_rr), .timeout(to_rr)
    );

    rr_arbiter4 #(.MAX_HOLD(3), .FIXED_PRI(1)) u_fp (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_fp), .gnt_id(id_fp), .gnt_valid(vld_fp), .timeout(to_fp)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(int k, logic [3:0] r);
        if (FP[k] != 0) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int j = 1; j <= 4; j++) if (r[(m_last[k] + j) % 4]) return (m_last[k] + j) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  w;
        bit  early, lim;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_owner[k] = -1; m_held[k] = 0; m_last[k] = 3; m_id[k] = 0; m_to[k] = 0;
            end else if (m_owner[k] < 0) begin
                m_to[k] = 0;
                w = pick(k, req);
                if (w >= 0) begin
                    m_owner[k] = w; m_id[k] = w; m_last[k] = w; m_held[k] = 1;
                end
            end else begin
                early = done || !req[m_owner[k]];
                lim   = (m_held[k] >= MH[k]);
                if (early || lim) begin
                    m_to[k]    = lim && !early;
                    m_owner[k] = -1;
                end else begin
                    m_to[k]   = 0;
                    m_held[k] = m_held[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_gnt(int k);
        return (m_owner[k] < 0) ? 8'd0 : (8'd1 << m_owner[k]);
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("rr_gnt",   {4'd0, gnt_rr}, exp_gnt(0));
        chk("rr_id",    {6'd0, id_rr},  8'(m_id[0]));
        chk("rr_valid", {7'd0, vld_rr}, {7'd0, (m_owner[0] >= 0)});
        chk("rr_to",    {7'd0, to_rr},  {7'd0, m_to[0]});
        chk("fp_gnt",   {4'd0, gnt_fp}, exp_gnt(1));
        chk("fp_id",    {6'd0, id_fp},  8'(m_id[1]));
        chk("fp_valid", {7'd0, vld_fp}, {7'd0, (m_owner[1] >= 0)});
        chk("fp_to",    {7'd0, to_fp},  {7'd0, m_to[1]});
    endtask

    logic [3:0] rr_seq [9];

    initial begin
        rr_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_last[k] = 3; m_id[k] = 0; m_to[k] = 0;
        end

        // Reset then arbitrate
        rst = 1'b1; req = 4'b0101; done = 1'b0;
        step(); chk("rst_gnt1", {4'd0, gnt_rr}, 8'h00);
        step(); chk("rst_gnt2", {4'd0, gnt_rr}, 8'h00);
        rst = 1'b0;
        step();
        chk("first_rr_gnt", {4'd0, gnt_rr}, 8'h01);
        chk("first_rr_id",  {6'd0, id_rr},  8'h00);
        chk("first_rr_vld", {7'd0, vld_rr}, 8'h01);
        chk("first_fp_gnt", {4'd0, gnt_fp}, 8'h04);

        // Round-robin fairness with one-cycle grants
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr_seq%0d", i), {4'd0, gnt_rr}, {4'd0, rr_seq[i]});
        end

        // Fixed priority, regrant after done
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0110; done = 1'b0;
        step(); chk("fp_gnt_a", {4'd0, gnt_fp}, 8'h04); chk("fp_id_a", {6'd0, id_fp}, 8'h02);
        step(); chk("fp_gnt_b", {4'd0, gnt_fp}, 8'h04);
        done = 1'b1;
        step(); chk("fp_rel", {4'd0, gnt_fp}, 8'h00);
        done = 1'b0;
        step(); chk("fp_regrant", {4'd0, gnt_fp}, 8'h04);

        // Hold-limit timeout
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0001; done = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("hold%0d_gnt", i), {4'd0, gnt_rr}, 8'h01);
            chk($sformatf("hold%0d_to", i),  {7'd0, to_rr},  8'h00);
        end
        step(); chk("to_gnt", {4'd0, gnt_rr}, 8'h00); chk("to_pulse", {7'd0, to_rr}, 8'h01);
        step(); chk("to_regrant", {4'd0, gnt_rr}, 8'h01); chk("to_clear", {7'd0, to_rr}, 8'h00);

        // Owner drop, no preemption
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b0010;
        step(); chk("drop_own", {4'd0, gnt_rr}, 8'h02);
        step();
        req = 4'b1001;
        step(); chk("drop_gnt", {4'd0, gnt_rr}, 8'h00); chk("drop_to", {7'd0, to_rr}, 8'h00);
        step(); chk("drop_next", {4'd0, gnt_rr}, 8'h08);

        // Reset in the third grant cycle
        rst = 1'b1; step();
        rst = 1'b0; req = 4'b1111; done = 1'b0;
        step(); step(); step();
        chk("mid_gc3", {4'd0, gnt_rr}, 8'h01);
        rst = 1'b1;
        step(); chk("mid_rst", {4'd0, gnt_rr}, 8'h00);
        rst = 1'b0;
        step(); chk("mid_regrant", {4'd0, gnt_rr}, 8'h01);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
